// File: rtl/sha_msg_padder.sv
// rtl/sha_msg_padder.sv - packs message bytes into padded 512-bit SHA-256 blocks
//
// Purpose: gathers bytes from the UART receiver into big-endian 512-bit blocks,
//    appends the SHA-256 0x80 marker, zero fill and 64-bit bit-length, and
//    hands each block to the compression core with first/last tags.
// Ports:
//    clk, rst        clock (rising edge), asynchronous active-high reset
//    i_byte*         byte stream in; o_byte_ready = padder can take a byte
//    o_block*        block out, valid held stable until i_block_ready
//    o_block_first   first block of a message (core reloads initial H)
//    o_block_last    final block of a message
//    o_len_err       sticky byte-counter wrap, cleared on next message start
module sha_msg_padder #(
   parameter int LEN_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   i_byte,
   input  logic         i_byte_valid,
   input  logic         i_byte_last,
   output logic         o_byte_ready,
   output logic [511:0] o_block,
   output logic         o_block_valid,
   input  logic         i_block_ready,
   output logic         o_block_first,
   output logic         o_block_last,
   output logic         o_len_err
);

   typedef enum logic [1:0] {FILL = 2'd0, OUT = 2'd1, EXTRA = 2'd2} state_t;
   typedef enum logic [1:0] {PAD_NONE = 2'd0, PAD_ZERO = 2'd1, PAD_80 = 2'd2} pad_t;

   state_t            state, state_nx;
   pad_t              pend;
   logic [0:63][7:0]  blk;        // element 0 is the most significant byte
   logic [5:0]        idx;
   logic [LEN_W-1:0]  byte_cnt;
   logic [LEN_W-1:0]  cnt_inc;
   logic              in_msg;     // a message has started and not yet finished
   logic              first_pend; // no block of the current message emitted yet
   logic              last_r;
   logic              len_err;
   logic              byte_acc;
   logic              blk_acc;
   logic              cnt_wrap;
   logic [63:0]       len_new;    // length including the byte being accepted
   logic [63:0]       len_cur;    // length already counted (used by EXTRA)

   function automatic logic [63:0] bit_len(input logic [LEN_W-1:0] n);
      return {{(64-LEN_W-3){1'b0}}, n, 3'b000};
   endfunction

   assign o_byte_ready  = (state == FILL) & ~rst;
   assign byte_acc      = i_byte_valid & o_byte_ready;
   assign o_block_valid = (state == OUT);
   assign blk_acc       = o_block_valid & i_block_ready;
   assign o_block_first = (state == OUT) & first_pend;
   assign o_block_last  = (state == OUT) & last_r;
   assign o_block       = blk;
   assign o_len_err     = len_err;
   assign cnt_inc       = byte_cnt + LEN_W'(1);
   assign cnt_wrap      = &byte_cnt;
   assign len_new       = bit_len(cnt_inc);
   assign len_cur       = bit_len(byte_cnt);

   always_comb begin
      state_nx = state;
      case (state)
         FILL:    if (byte_acc && (i_byte_last || idx == 6'd63)) state_nx = OUT;
         OUT:     if (blk_acc) state_nx = (pend != PAD_NONE) ? EXTRA : FILL;
         EXTRA:   state_nx = OUT;
         default: state_nx = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FILL;
         pend       <= PAD_NONE;
         blk        <= '0;
         idx        <= '0;
         byte_cnt   <= '0;
         in_msg     <= 1'b0;
         first_pend <= 1'b0;
         last_r     <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            FILL: begin
               if (byte_acc) begin
                  blk[idx] <= i_byte;
                  idx      <= idx + 6'd1;
                  byte_cnt <= cnt_inc;
                  if (!in_msg) begin
                     in_msg     <= 1'b1;
                     first_pend <= 1'b1;
                     len_err    <= cnt_wrap;
                  end else begin
                     len_err    <= len_err | cnt_wrap;
                  end
                  if (i_byte_last) begin
                     // Buffer is already zero past idx, so only the marker
                     // and (when it fits) the length need writing.
                     if (idx <= 6'd54) begin
                        blk[idx + 6'd1] <= 8'h80;
                        for (int i = 0; i < 8; i++) blk[56 + i] <= len_new[63 - 8*i -: 8];
                        last_r <= 1'b1;
                        pend   <= PAD_NONE;
                     end else if (idx <= 6'd62) begin
                        blk[idx + 6'd1] <= 8'h80;
                        last_r <= 1'b0;
                        pend   <= PAD_ZERO;
                     end else begin
                        last_r <= 1'b0;
                        pend   <= PAD_80;
                     end
                  end else if (idx == 6'd63) begin
                     last_r <= 1'b0;
                     pend   <= PAD_NONE;
                  end
               end
            end
            OUT: begin
               if (blk_acc) begin
                  // Clear so stale bytes never leak into the next block.
                  blk        <= '0;
                  idx        <= '0;
                  first_pend <= 1'b0;
                  if (last_r) begin
                     byte_cnt <= '0;
                     in_msg   <= 1'b0;
                  end
               end
            end
            EXTRA: begin
               blk[0] <= (pend == PAD_80) ? 8'h80 : 8'h00;
               for (int i = 0; i < 8; i++) blk[56 + i] <= len_cur[63 - 8*i -: 8];
               last_r <= 1'b1;
               pend   <= PAD_NONE;
            end
            default: ;
         endcase
      end
   end

endmodule
